// File: rtl/core_param_pkg.sv
// rtl/core_param_pkg.sv - ISA types, opcodes and selector helpers for the CA processing element
package core_param_pkg;
   localparam int SEL_W = 5;
   localparam int PC_W  = 8;
   localparam int SP_W  = 4;
   localparam int IMM_W = 16;

   // neighbour slice order within i_nb
   localparam int NB_N  = 0;
   localparam int NB_W  = 1;
   localparam int NB_E  = 2;
   localparam int NB_S  = 3;
   localparam int NB_NW = 4;
   localparam int NB_NE = 5;
   localparam int NB_SW = 6;
   localparam int NB_SE = 7;

   typedef enum logic [3:0] {
      OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_MASK, OP_MUL, OP_DIV
   } opcode_t;

   typedef logic [PC_W-1:0] pc_t;
   typedef logic [SP_W-1:0] sp_t;

   typedef struct packed {
      opcode_t          op;
      logic [SEL_W-1:0] tgt;
      logic [SEL_W-1:0] src_a;
      logic [SEL_W-1:0] src_b;
      logic [IMM_W-1:0] imm;
   } instruction_t;

   function automatic int sel_zero(int r);
      return r + 1;
   endfunction

   function automatic int sel_x(int r);
      return r + 2;
   endfunction

   function automatic int sel_y(int r);
      return r + 3;
   endfunction

   function automatic int sel_nb0(int r);
      return r + 4;
   endfunction

   function automatic logic is_muldiv(opcode_t op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction
endpackage

// File: rtl/core_param_if.sv
// rtl/core_param_if.sv - broadcast/controller bus between the array and one processing element
interface core_param_if import core_param_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int NB    = 4
);
   logic              global_enable;
   instruction_t      instruction;
   pc_t               next_program_counter;
   sp_t               next_stack_pointer;
   logic [WIDTH-1:0]  i_self;
   logic [NB*WIDTH-1:0] i_nb;
   logic [WIDTH-1:0]  nextState;
   logic [WIDTH-1:0]  nextVideo;
   logic              diverge;
   logic              busy;

   modport master (
      output global_enable, instruction, next_program_counter, next_stack_pointer, i_self, i_nb,
      input  nextState, nextVideo, diverge, busy
   );

   modport slave (
      input  global_enable, instruction, next_program_counter, next_stack_pointer, i_self, i_nb,
      output nextState, nextVideo, diverge, busy
   );
endinterface

// File: rtl/core_alu.sv
// rtl/core_alu.sv - single-cycle combinational ALU
module core_alu import core_param_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  opcode_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic [WIDTH-1:0] result,
   output logic             writes
);
   always_comb begin
      result = '0;
      writes = 1'b1;
      case (op)
         OP_LDI:  result = WIDTH'(imm);
         OP_MOV:  result = a;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = a << b;
         OP_SHR:  result = a >> b;
         default: writes = 1'b0;
      endcase
   end
endmodule

// File: rtl/core_control.sv
// rtl/core_control.sv - divergence mask: a cell masks itself on a zero condition until the rejoin point
module core_control import core_param_pkg::*; (
   input  logic    clk,
   input  logic    rst,
   input  logic    enable,
   input  opcode_t op,
   input  logic    cond_zero,
   input  pc_t     rejoin_target,
   input  pc_t     next_program_counter,
   input  sp_t     next_stack_pointer,
   output logic    local_enable,
   output logic    diverge
);
   pc_t rejoin_pc;
   sp_t rejoin_sp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diverge   <= 1'b0;
         rejoin_pc <= '0;
         rejoin_sp <= '0;
      end else if (enable) begin
         if (diverge) begin
            if (next_program_counter == rejoin_pc && next_stack_pointer == rejoin_sp)
               diverge <= 1'b0;
         end else if (op == OP_MASK && cond_zero) begin
            diverge   <= 1'b1;
            rejoin_pc <= rejoin_target;
            rejoin_sp <= next_stack_pointer;
         end
      end
   end

   assign local_enable = enable && !diverge;
endmodule

// File: rtl/core_muldiv.sv
// rtl/core_muldiv.sv - iterative unsigned shift-add multiplier / restoring divider, WIDTH steps
module core_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             enable,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count;
   logic             div_q;
   logic [WIDTH-1:0] p, q, d, p_n, q_n, d_n;
   logic [WIDTH:0]   shifted, diff;
   logic             ge;

   // MUL: p=accumulator, q=multiplier, d=multiplicand. DIV: p=remainder, q=quotient, d=divisor.
   always_comb begin
      shifted = {p, q[WIDTH-1]};
      diff    = shifted - {1'b0, d};
      ge      = shifted >= {1'b0, d};
      if (div_q) begin
         p_n = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         q_n = {q[WIDTH-2:0], ge};
         d_n = d;
      end else begin
         p_n = p + (q[0] ? d : '0);
         q_n = q >> 1;
         d_n = d << 1;
      end
   end

   assign result = div_q ? q_n : p_n;
   assign last   = busy && enable && (count == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy  <= 1'b0;
         count <= '0;
         div_q <= 1'b0;
         p     <= '0;
         q     <= '0;
         d     <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         count <= CW'(WIDTH);
         div_q <= op_div;
         p     <= '0;
         q     <= op_div ? a : b;
         d     <= op_div ? b : a;
      end else if (busy && enable) begin
         p     <= p_n;
         q     <= q_n;
         d     <= d_n;
         count <= count - CW'(1);
         if (count == CW'(1))
            busy <= 1'b0;
      end
   end
endmodule

// File: rtl/core_param.sv
// rtl/core_param.sv - parametrised cellular-automaton processing element with multi-cycle MUL/DIV
module core_param import core_param_pkg::*; #(
   parameter int X        = 0,
   parameter int Y        = 0,
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int MOORE    = 0
) (
   input logic clk,
   input logic rst,
   core_param_if.slave bus
);
   localparam int NB = (MOORE != 0) ? 8 : 4;
   localparam logic [SEL_W-1:0] SEL_VIDEO = SEL_W'(sel_zero(NUM_REGS));

   logic [WIDTH-1:0] regs [1:NUM_REGS];
   logic [WIDTH-1:0] video;
   logic [WIDTH-1:0] src_tbl [0:(1<<SEL_W)-1];
   logic [WIDTH-1:0] op_a, op_b, alu_result, md_result, next_state, wb_val;
   logic             alu_writes, local_enable, issue_ok, md_start, md_busy, md_last, wb_en;
   logic [SEL_W-1:0] md_tgt, wb_tgt;
   opcode_t          op;

   assign op = bus.instruction.op;

   // Unlisted selector values stay zero, so out-of-range reads return 0.
   always_comb begin
      for (int k = 0; k < (1 << SEL_W); k++) src_tbl[k] = '0;
      src_tbl[0] = bus.i_self;
      for (int r = 1; r <= NUM_REGS; r++) src_tbl[r] = regs[r];
      src_tbl[sel_x(NUM_REGS)] = WIDTH'(X);
      src_tbl[sel_y(NUM_REGS)] = WIDTH'(Y);
      for (int k = 0; k < NB; k++) src_tbl[sel_nb0(NUM_REGS) + k] = bus.i_nb[k*WIDTH +: WIDTH];
   end

   assign op_a = src_tbl[bus.instruction.src_a];
   assign op_b = src_tbl[bus.instruction.src_b];

   core_alu #(.WIDTH(WIDTH)) u_alu (
      .op(op), .a(op_a), .b(op_b), .imm(bus.instruction.imm),
      .result(alu_result), .writes(alu_writes)
   );

   core_control u_control (
      .clk(clk), .rst(rst), .enable(bus.global_enable && !md_busy), .op(op),
      .cond_zero(op_a == '0), .rejoin_target(pc_t'(bus.instruction.imm)),
      .next_program_counter(bus.next_program_counter),
      .next_stack_pointer(bus.next_stack_pointer),
      .local_enable(local_enable), .diverge(bus.diverge)
   );

   assign issue_ok = local_enable && !md_busy;
   assign md_start = issue_ok && is_muldiv(op);

   core_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk(clk), .rst(rst), .start(md_start), .enable(bus.global_enable),
      .op_div(op == OP_DIV), .a(op_a), .b(op_b),
      .busy(md_busy), .last(md_last), .result(md_result)
   );

   always_comb begin
      wb_en  = 1'b0;
      wb_tgt = bus.instruction.tgt;
      wb_val = alu_result;
      if (md_last) begin
         wb_en  = 1'b1;
         wb_tgt = md_tgt;
         wb_val = md_result;
      end else if (issue_ok && alu_writes) begin
         wb_en = 1'b1;
      end
   end

   always_comb begin
      next_state = bus.i_self;
      if (!rst && wb_en && wb_tgt == '0)
         next_state = wb_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r <= NUM_REGS; r++) regs[r] <= '0;
         video  <= '0;
         md_tgt <= '0;
      end else begin
         if (md_start)
            md_tgt <= bus.instruction.tgt;
         if (wb_en) begin
            for (int r = 1; r <= NUM_REGS; r++)
               if (wb_tgt == SEL_W'(r)) regs[r] <= wb_val;
            if (wb_tgt == SEL_VIDEO)
               video <= wb_val;
         end
      end
   end

   assign bus.nextState = next_state;
   assign bus.nextVideo = video;
   assign bus.busy      = md_busy;
endmodule

// File: tb/tb_core_param.sv
// tb/tb_core_param.sv - directed bench for core_param (Moore and von Neumann instances side by side)
module tb_core_param;
   import core_param_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         ge;
   instruction_t instr;
   pc_t          pc;
   sp_t          sp;
   logic [7:0]   self_v;
   logic [63:0]  nb;
   int           n_chk = 0;
   int           n_fail = 0;
   int           n, hits, hit_at;
   logic [7:0]   hit_val;

   core_param_if #(.WIDTH(8), .NB(8)) bus_m ();
   core_param_if #(.WIDTH(8), .NB(4)) bus_v ();

   assign bus_m.global_enable = ge;
   assign bus_m.instruction = instr;
   assign bus_m.next_program_counter = pc;
   assign bus_m.next_stack_pointer = sp;
   assign bus_m.i_self = self_v;
   assign bus_m.i_nb = nb;
   assign bus_v.global_enable = ge;
   assign bus_v.instruction = instr;
   assign bus_v.next_program_counter = pc;
   assign bus_v.next_stack_pointer = sp;
   assign bus_v.i_self = self_v;
   assign bus_v.i_nb = nb[31:0];

   core_param #(.X(3), .Y(5), .WIDTH(8), .NUM_REGS(8), .MOORE(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
   core_param #(.X(0), .Y(0), .WIDTH(8), .NUM_REGS(8), .MOORE(0)) dut_v (.clk(clk), .rst(rst), .bus(bus_v));

   // selectors with NUM_REGS=8: MY=0 R1..R8=1..8 ZERO/VIDEO=9 X=10 Y=11 N=12 W=13 E=14 S=15 NW=16 NE=17
   function automatic instruction_t mk(input opcode_t op, input int t, input int a, input int b, input int imm);
      instruction_t m;
      m.op = op;
      m.tgt = 5'(t);
      m.src_a = 5'(a);
      m.src_b = 5'(b);
      m.imm = 16'(imm);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic run_busy(input int drop_at, output int cycles);
      cycles = 0;
      while (bus_m.busy === 1'b1 && cycles < 64) begin
         cycles++;
         ge = !(drop_at > 0 && cycles >= drop_at && cycles < drop_at + 3);
         cyc();
      end
      ge = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ge = 1'b0; pc = '0; sp = '0; self_v = 8'd2;
      instr = mk(OP_NOP, 0, 0, 0, 0);
      nb = {8'h88, 8'h77, 8'h3C, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      cyc(); cyc();
      chk("rst_busy", 32'(bus_m.busy), 0);
      chk("rst_state", 32'(bus_m.nextState), 2);
      chk("rst_video", 32'(bus_m.nextVideo), 0);
      chk("rst_diverge", 32'(bus_m.diverge), 0);

      rst = 1'b0; ge = 1'b1;
      instr = mk(OP_LDI, 1, 0, 0, 5); #1 chk("ldi_not_my", 32'(bus_m.nextState), 2);
      cyc(); instr = mk(OP_ADD, 0, 1, 9, 0); #1 chk("add_my_r1_zero", 32'(bus_m.nextState), 5);
      cyc(); instr = mk(OP_MOV, 9, 1, 0, 0);
      cyc(); chk("video_r1", 32'(bus_m.nextVideo), 5);

      instr = mk(OP_MOV, 0, 1, 0, 0); #1 chk("readback_r1", 32'(bus_m.nextState), 5);
      #1 rst = 1'b1;
      #1 chk("rst_async_state", 32'(bus_m.nextState), 2);
      chk("rst_async_video", 32'(bus_m.nextVideo), 0);
      cyc(); rst = 1'b0; #1 chk("regs_cleared", 32'(bus_m.nextState), 0);

      cyc(); instr = mk(OP_LDI, 1, 0, 0, 13);
      cyc(); instr = mk(OP_LDI, 3, 0, 0, 11);
      cyc(); instr = mk(OP_MUL, 2, 1, 3, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      run_busy(0, n); chk("mul_busy_cycles", 32'(n), 8);
      instr = mk(OP_MOV, 0, 2, 0, 0); #1 chk("mul_13x11", 32'(bus_m.nextState), 143);

      cyc(); instr = mk(OP_LDI, 1, 0, 0, 20);
      cyc(); instr = mk(OP_MUL, 2, 1, 1, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      run_busy(0, n);
      instr = mk(OP_MOV, 0, 2, 0, 0); #1 chk("mul_20x20_trunc", 32'(bus_m.nextState), 144);

      cyc(); instr = mk(OP_LDI, 1, 0, 0, 100);
      cyc(); instr = mk(OP_LDI, 3, 0, 0, 7);
      cyc(); instr = mk(OP_DIV, 0, 1, 3, 0); #1 chk("div_issue_state", 32'(bus_m.nextState), 2);
      cyc(); instr = mk(OP_MOV, 0, 1, 0, 0);
      n = 0; hits = 0; hit_at = 0; hit_val = '0;
      while (bus_m.busy === 1'b1 && n < 64) begin
         n++;
         #1;
         if (bus_m.nextState !== 8'd2) begin
            hits++; hit_at = n; hit_val = bus_m.nextState;
         end
         cyc();
      end
      chk("div_busy_cycles", 32'(n), 8);
      chk("div_result_cycles", 32'(hits), 1);
      chk("div_result_on_last", 32'(hit_at), 8);
      chk("div_100_7", 32'(hit_val), 14);
      #1 chk("held_instr_issues", 32'(bus_m.nextState), 100);

      cyc(); instr = mk(OP_LDI, 3, 0, 0, 0);
      cyc(); instr = mk(OP_DIV, 2, 1, 3, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      run_busy(0, n); chk("div0_busy_cycles", 32'(n), 8);
      instr = mk(OP_MOV, 0, 2, 0, 0); #1 chk("div0_all_ones", 32'(bus_m.nextState), 255);

      cyc(); instr = mk(OP_LDI, 1, 0, 0, 13);
      cyc(); instr = mk(OP_LDI, 3, 0, 0, 11);
      cyc(); instr = mk(OP_MUL, 4, 1, 3, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      run_busy(3, n); chk("stall_busy_cycles", 32'(n), 11);
      instr = mk(OP_MOV, 0, 4, 0, 0); #1 chk("stall_mul_result", 32'(bus_m.nextState), 143);

      cyc(); instr = mk(OP_MOV, 4, 17, 0, 0);
      cyc(); instr = mk(OP_MOV, 0, 4, 0, 0);
      #1 chk("moore_ne", 32'(bus_m.nextState), 32'h3C);
      chk("vn_ne_out_of_range", 32'(bus_v.nextState), 0);
      cyc(); instr = mk(OP_MOV, 0, 12, 0, 0); #1 chk("vn_north", 32'(bus_v.nextState), 32'h11);
      cyc(); instr = mk(OP_LDI, 10, 0, 0, 8'h77);
      cyc(); instr = mk(OP_MOV, 0, 10, 0, 0); #1 chk("x_write_ignored", 32'(bus_m.nextState), 3);
      cyc(); instr = mk(OP_MOV, 0, 11, 0, 0); #1 chk("read_y", 32'(bus_m.nextState), 5);

      cyc(); instr = mk(OP_LDI, 1, 0, 0, 100);
      cyc(); instr = mk(OP_LDI, 3, 0, 0, 7);
      cyc(); instr = mk(OP_DIV, 5, 1, 3, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      cyc(); cyc(); cyc();
      chk("div_busy_4th", 32'(bus_m.busy), 1);
      #1 rst = 1'b1;
      #1 chk("rst_busy_async", 32'(bus_m.busy), 0);
      cyc(); rst = 1'b0;
      instr = mk(OP_MOV, 0, 5, 0, 0); #1 chk("rst_div_target_zero", 32'(bus_m.nextState), 0);
      cyc(); instr = mk(OP_LDI, 1, 0, 0, 9);
      cyc(); instr = mk(OP_LDI, 3, 0, 0, 3);
      cyc(); instr = mk(OP_MUL, 5, 1, 3, 0);
      cyc(); instr = mk(OP_NOP, 0, 0, 0, 0);
      run_busy(0, n); chk("post_rst_busy_cycles", 32'(n), 8);
      instr = mk(OP_MOV, 0, 5, 0, 0); #1 chk("post_rst_mul", 32'(bus_m.nextState), 27);

      cyc(); instr = mk(OP_MASK, 0, 9, 0, 5);
      cyc(); chk("mask_diverge", 32'(bus_m.diverge), 1);
      instr = mk(OP_MUL, 6, 1, 3, 0);
      cyc(); chk("masked_no_busy", 32'(bus_m.busy), 0);
      instr = mk(OP_ADD, 0, 1, 3, 0); #1 chk("masked_state", 32'(bus_m.nextState), 2);
      pc = 8'd5;
      cyc(); chk("rejoin", 32'(bus_m.diverge), 0);
      pc = '0; instr = mk(OP_ADD, 0, 1, 3, 0); #1 chk("rejoined_add", 32'(bus_m.nextState), 12);

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/core_param.md
Name: core_param

Overview:
- Next-generation cellular-automaton processing element, parametrised in data width, general-register count and neighbourhood (von Neumann or Moore).
- Adds a multi-cycle unsigned MUL/DIV unit with a busy/stall output. Single-cycle ALU ops keep existing ISA semantics.
- Instantiated once per grid cell by the array generator; driven by the shared instruction broadcast and the global controller.

Parameters:
- X, 0, cell column coordinate, readable as source.
- Y, 0, cell row coordinate, readable as source.
- WIDTH, 8, datapath/state width in bits (4..32).
- NUM_REGS, 8, general registers R1..R(NUM_REGS) (1..16).
- MOORE, 0, 0 = 4 neighbours (N,W,E,S); 1 = 8 neighbours (adds NW,NE,SW,SE).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- global_enable  in  1  array-wide execute enable from controller
- instruction  in  instruction_t  broadcast instruction
- next_program_counter  in  pc_t  forwarded to core_control
- next_stack_pointer  in  sp_t  forwarded to core_control
- i_self  in  WIDTH  this cell's current state
- i_nb  in  NB*WIDTH  neighbour states, NB = MOORE ? 8 : 4, slice k = neighbour k in order N,W,E,S,NW,NE,SW,SE
- nextState  out  WIDTH  state to commit to the cell array
- nextVideo  out  WIDTH  video register
- diverge  out  1  from core_control
- busy  out  1  multi-cycle op in flight; OR-reduced by controller into array stall

Behaviour:
- Reset (async, any time, including mid-MUL/DIV):
  - regs, video and busy go to 0; MUL/DIV counter cleared and the operation is discarded.
  - nextState = i_self.
- Source/target encoding:
  - 0 = MY; 1..R = regs (R = NUM_REGS); R+1 = ZERO (as target: VIDEO); R+2 = X; R+3 = Y; R+4..R+3+NB = neighbours.
  - Selector width = clog2(R+4+NB).
  - Writes to X, Y or neighbour indices are ignored. Reading an out-of-range index yields 0.
- local_enable comes from core_control (global_enable gated by divergence mask).
- Single-cycle ops: result computed combinationally, written at the next clk edge when local_enable && !busy. Target MY: nextState = result in the same cycle, otherwise i_self.
- MUL/DIV issue: on an edge with local_enable && !busy && opcode in {OP_MUL, OP_DIV}:
  - latch operands, target and op;
  - busy<=1, count<=WIDTH.
- Iteration:
  - MUL: shift-add; DIV: restoring. One step per edge while busy && global_enable; count decrements each step.
  - global_enable low freezes the unit, and busy stays high.
- Completion: on the step edge where count goes 1->0:
  - result written to target; busy<=0.
  - During that final busy cycle (count==1 && global_enable), nextState = result if target MY.
  - Total: issue edge + WIDTH step edges, so busy is high for exactly WIDTH enabled cycles.
- Arithmetic:
  - Unsigned. MUL keeps low WIDTH bits of the product.
  - DIV returns the quotient. Divide by zero returns all-ones, takes the same WIDTH cycles, no exception.
- While busy:
  - instruction input is ignored (controller holds PC via busy).
  - No register writes other than the completion writeback; nextState = i_self except at completion.
- Simultaneous completion and new instruction: the completion edge only writes back. The held instruction issues on the following edge, once busy is 0.
- Divergence: a masked core (local_enable=0) never issues and busy stays 0.

Decomposition:
- isa package:
  - OP_MUL and OP_DIV opcode constants;
  - parametrised selector helpers (index of ZERO/X/Y/first neighbour as functions of R, NB);
  - neighbour-order localparams.
- core_alu gains a WIDTH parameter.
- Natural sub-module: core_muldiv (operand latch, counter, shift-add/restoring datapath, done pulse). core_control is reused unchanged.

Test Plan:
- Reset, then write 5 to R1 via immediate; ADD MY,R1,ZERO with i_self=2 -> nextState=5 in that cycle, R1 readback 5; assert rst mid-cycle -> regs 0 and nextState=i_self immediately.
- WIDTH=8: MUL R2,R1(13),R3(11) -> busy high for 8 cycles, R2=143; 20*20 -> R2=144 (truncated).
- DIV MY,R1(100),R3(7) -> busy 8 cycles, nextState=14 only on final busy cycle; divisor 0 -> 255.
- MUL with global_enable dropped 3 cycles mid-op -> busy lasts 11 cycles total, result still correct.
- MOORE=1: read NE neighbour slice (value 0x3C) into R4 -> R4=0x3C; MOORE=0 same selector -> 0. Write to X index ignored.
- Assert rst on 4th busy cycle of DIV -> busy 0 asynchronously, target register stays 0, next instruction issues normally.
